// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline: ALU command codes, the decoded
// control word carried between stages, and the default datapath width.
package arm_pkg;

  localparam int DW_DEFAULT = 32;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       branch;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  // A bubble: no writeback, no memory access, no branch, no flag update.
  localparam ctrl_t CTRL_NOP = '{wb_en: 1'b0, mem_r_en: 1'b0, mem_w_en: 1'b0,
                                 branch: 1'b0, s: 1'b0, exe_cmd: EXE_NOP};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; used to count pipeline bubbles.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_d;

  // NOTE: assign the default first so every path through always_comb drives cnt_d; otherwise a latch is inferred.
  always_comb begin
    cnt_d = cnt;
    if (inc && !hold && (cnt != '1)) cnt_d = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_d;
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EX pipeline register: captures the decoded instruction, supports freeze,
// flush and bubble (NOP) insertion, and counts inserted bubbles.
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             bubble,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             branch_in,
  input  logic             s_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic             carry_in,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             branch_out,
  output logic             s_out,
  output logic [3:0]       exe_cmd_out,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    val_rn_out,
  output logic [DW-1:0]    val_rm_out,
  output logic             imm_out,
  output logic [11:0]      shift_operand_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic             carry_out,
  output logic             valid_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  load_nop;

  assign ctrl_d = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                    branch: branch_in, s: s_in, exe_cmd: exe_cmd_in};
  assign load_nop = flush | bubble;

  // Freeze outranks flush/bubble: a frozen stage neither loads nor clears.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || (!freeze && load_nop)) begin
      ctrl_q            <= CTRL_NOP;
      pc_out            <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm24_out  <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      carry_out         <= 1'b0;
      valid_out         <= 1'b0;
    end else if (!freeze) begin
      ctrl_q            <= ctrl_d;
      pc_out            <= pc_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm24_out  <= signed_imm24_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      carry_out         <= carry_in;
      valid_out         <= 1'b1;
    end
  end

  assign wb_en_out    = ctrl_q.wb_en;
  assign mem_r_en_out = ctrl_q.mem_r_en;
  assign mem_w_en_out = ctrl_q.mem_w_en;
  assign branch_out   = ctrl_q.branch;
  assign s_out        = ctrl_q.s;
  assign exe_cmd_out  = ctrl_q.exe_cmd;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (load_nop),
    .hold (freeze),
    .cnt  (bubble_cnt)
  );

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed scenarios plus a random run, all checked
// against a field-level reference model of the register's behaviour.
module tb_id_exe_reg;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        branch;
    logic        s;
    logic [3:0]  exe_cmd;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        carry;
  } fields_t;

  logic    clk;
  logic    rst, freeze, flush, bubble;
  fields_t din;

  logic        wb_en_out, mem_r_en_out, mem_w_en_out, branch_out, s_out;
  logic [3:0]  exe_cmd_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm24_out;
  logic [3:0]  dest_out, src1_out, src2_out;
  logic        carry_out, valid_out;
  logic [15:0] bubble_cnt;
  fields_t     dout;

  logic        n_wb_en, n_mem_r_en, n_mem_w_en, n_branch, n_s;
  logic [3:0]  n_exe_cmd;
  logic [31:0] n_pc, n_val_rn, n_val_rm;
  logic        n_imm;
  logic [11:0] n_shift_operand;
  logic [23:0] n_signed_imm24;
  logic [3:0]  n_dest, n_src1, n_src2;
  logic        n_carry, n_valid;
  logic [1:0]  n_bubble_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  fields_t m_f;
  logic    m_valid;
  int      m_cnt;
  int      m_cnt2;

  assign dout = {wb_en_out, mem_r_en_out, mem_w_en_out, branch_out, s_out, exe_cmd_out,
                 pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
                 signed_imm24_out, dest_out, src1_out, src2_out, carry_out};

  id_exe_reg #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .wb_en_in(din.wb_en), .mem_r_en_in(din.mem_r_en), .mem_w_en_in(din.mem_w_en),
    .branch_in(din.branch), .s_in(din.s), .exe_cmd_in(din.exe_cmd),
    .pc_in(din.pc), .val_rn_in(din.val_rn), .val_rm_in(din.val_rm), .imm_in(din.imm),
    .shift_operand_in(din.shift_operand), .signed_imm24_in(din.signed_imm24),
    .dest_in(din.dest), .src1_in(din.src1), .src2_in(din.src2), .carry_in(din.carry),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
    .branch_out(branch_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out),
    .valid_out(valid_out), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance for the saturation scenario
  id_exe_reg #(.DW(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
    .wb_en_in(din.wb_en), .mem_r_en_in(din.mem_r_en), .mem_w_en_in(din.mem_w_en),
    .branch_in(din.branch), .s_in(din.s), .exe_cmd_in(din.exe_cmd),
    .pc_in(din.pc), .val_rn_in(din.val_rn), .val_rm_in(din.val_rm), .imm_in(din.imm),
    .shift_operand_in(din.shift_operand), .signed_imm24_in(din.signed_imm24),
    .dest_in(din.dest), .src1_in(din.src1), .src2_in(din.src2), .carry_in(din.carry),
    .wb_en_out(n_wb_en), .mem_r_en_out(n_mem_r_en), .mem_w_en_out(n_mem_w_en),
    .branch_out(n_branch), .s_out(n_s), .exe_cmd_out(n_exe_cmd),
    .pc_out(n_pc), .val_rn_out(n_val_rn), .val_rm_out(n_val_rm), .imm_out(n_imm),
    .shift_operand_out(n_shift_operand), .signed_imm24_out(n_signed_imm24),
    .dest_out(n_dest), .src1_out(n_src1), .src2_out(n_src2), .carry_out(n_carry),
    .valid_out(n_valid), .bubble_cnt(n_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic fields_t rand_fields();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return fields_t'(r[$bits(fields_t)-1:0]);
  endfunction

  // Model of one clock edge, taken straight from the priority rules.
  task automatic model_edge();
    if (!rst) begin
      m_f = '0; m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else if (freeze) begin
      // everything holds
    end else if (flush || bubble) begin
      m_f = '0; m_valid = 1'b0;
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : 3;
    end else begin
      m_f = din; m_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("fields", 160'(dout), 160'(m_f));
    check("valid", 160'(valid_out), 160'(m_valid));
    check("bubble_cnt", 160'(bubble_cnt), 160'(m_cnt));
    check("bubble_cnt_w2", 160'(n_bubble_cnt), 160'(m_cnt2));
  endtask

  initial begin
    m_f = '0; m_valid = 1'b0; m_cnt = 0; m_cnt2 = 0;
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    din = rand_fields();

    // Reset held for two edges with random inputs, then release
    for (int i = 0; i < 2; i++) begin
      din = rand_fields();
      freeze = 1'($urandom); flush = 1'($urandom); bubble = 1'($urandom);
      tick();
      check("rst_all_zero", 160'({dout, valid_out, bubble_cnt}), 160'(0));
    end
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; bubble = 1'b0;
    din = rand_fields(); din.exe_cmd = 4'b0010;
    tick();
    check("post_rst_exe_cmd", 160'(exe_cmd_out), 160'(4'b0010));
    check("post_rst_valid", 160'(valid_out), 160'(1'b1));

    // ADD then CMP pass through
    din = rand_fields();
    din.wb_en = 1'b1; din.mem_r_en = 1'b0; din.mem_w_en = 1'b0; din.branch = 1'b0; din.s = 1'b0;
    din.exe_cmd = 4'b0010; din.val_rn = 32'h5; din.dest = 4'd3;
    tick();
    check("add_ctrl", 160'({wb_en_out, s_out, exe_cmd_out}), 160'({1'b1, 1'b0, 4'b0010}));
    check("add_data", 160'({val_rn_out, dest_out}), 160'({32'h5, 4'd3}));
    din = rand_fields();
    din.wb_en = 1'b0; din.mem_r_en = 1'b0; din.mem_w_en = 1'b0; din.branch = 1'b0; din.s = 1'b1;
    din.exe_cmd = 4'b0100;
    tick();
    check("cmp_ctrl", 160'({wb_en_out, s_out, exe_cmd_out}), 160'({1'b0, 1'b1, 4'b0100}));
    check("cmp_cnt", 160'(bubble_cnt), 160'(0));

    // Freeze holds the PC
    din = rand_fields(); din.pc = 32'h40;
    tick();
    check("frz_load", 160'(pc_out), 160'(32'h40));
    freeze = 1'b1; din.pc = 32'h44;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_hold", 160'(pc_out), 160'(32'h40));
    end
    freeze = 1'b0;
    tick();
    check("frz_release", 160'(pc_out), 160'(32'h44));

    // Flush during freeze is deferred until freeze drops
    freeze = 1'b1; flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frzflush_hold", 160'({pc_out, valid_out, bubble_cnt}), 160'({32'h44, 1'b1, 16'd0}));
    end
    freeze = 1'b0;
    tick();
    check("frzflush_nop", 160'({dout, valid_out}), 160'(0));
    check("frzflush_cnt", 160'(bubble_cnt), 160'(1));
    flush = 1'b0;

    // Load-use hazard: STR behind LDR becomes a bubble
    din = rand_fields(); din.mem_r_en = 1'b1; din.mem_w_en = 1'b0;
    tick();
    check("ldr_load", 160'(mem_r_en_out), 160'(1'b1));
    din = rand_fields(); din.mem_w_en = 1'b1; din.exe_cmd = 4'b0010; bubble = 1'b1;
    tick();
    check("bub_nop", 160'({mem_w_en_out, exe_cmd_out}), 160'(0));
    check("bub_cnt", 160'(bubble_cnt), 160'(2));
    flush = 1'b1;
    tick();
    check("flushbub_cnt", 160'(bubble_cnt), 160'(3));
    flush = 1'b0; bubble = 1'b0;

    // Saturation on the 2-bit counter
    rst = 1'b0;
    tick();
    rst = 1'b1; bubble = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = rand_fields();
      tick();
      check("sat_w2", 160'(n_bubble_cnt), 160'((i < 3) ? i + 1 : 3));
      check("sat_w16", 160'(bubble_cnt), 160'(i + 1));
    end
    bubble = 1'b0;

    // Random run against the model
    for (int i = 0; i < 400; i++) begin
      din    = rand_fields();
      rst    = ($urandom_range(0, 29) != 0);
      freeze = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 5) == 0);
      bubble = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
